div_operand_queue: RTL and testbench

Operand staging block that sits directly upstream of the integer `divider` stage. It accepts dividend/divisor pairs over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drives `data1`/`data2` into the divider one pair per cycle and screens divide-by-zero and signed-overflow pairs. It tracks each issued pair through the divider's one-cycle latency and presents the divider's q/r on its own result port, with corrections and flags applied.

---
 rtl/div_operand_queue.sv | 138 +++++++++++++
 tb/tb_div_operand_queue.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_queue.sv
// Operand FIFO and issue/tracking pipeline in front of the one-cycle divider.
// Screens divide-by-zero and MIN_INT/-1 pairs and corrects the divider's q/r.
module div_operand_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_dividend,
    input  logic [WIDTH-1:0]           in_divisor,
    input  logic                       issue_en,
    output logic [WIDTH-1:0]           data1,
    output logic [WIDTH-1:0]           data2,
    input  logic [WIDTH-1:0]           div_q,
    input  logic [WIDTH-1:0]           div_r,
    output logic                       res_valid,
    output logic [WIDTH-1:0]           res_q,
    output logic [WIDTH-1:0]           res_r,
    output logic                       res_dz,
    output logic                       res_ovf,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;
    logic             r_s1_valid;
    logic             r_s1_dz;
    logic             r_s1_ovf;

    logic             r_s2_valid;
    logic             r_s2_dz;
    logic             r_s2_ovf;
    logic [WIDTH-1:0] r_s2_dividend;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;
    logic             w_dz;
    logic             w_ovf;

    assign in_ready = (r_level != LW'(DEPTH));
    assign level    = r_level;
    assign data1    = r_data1;
    assign data2    = r_data2;

    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_level != '0) && issue_en;
    assign w_head_a = r_mem_a[r_rd_ptr];
    assign w_head_b = r_mem_b[r_rd_ptr];
    assign w_dz     = (w_head_b == '0);
    assign w_ovf    = (w_head_a == MIN_INT) && (w_head_b == '1);

    // Storage needs no reset; pointers and level define validity.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_dividend;
            r_mem_b[r_wr_ptr] <= in_divisor;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (!w_push && w_pop)
                r_level <= r_level - LW'(1);
        end
    end

    // Issue stage: the divider never sees a zero divisor.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_data1    <= '0;
            r_data2    <= ONE;
            r_s1_valid <= 1'b0;
            r_s1_dz    <= 1'b0;
            r_s1_ovf   <= 1'b0;
        end else if (w_pop) begin
            r_data1    <= w_head_a;
            r_data2    <= (w_dz || w_ovf) ? ONE : w_head_b;
            r_s1_valid <= 1'b1;
            r_s1_dz    <= w_dz;
            r_s1_ovf   <= w_ovf;
        end else begin
            r_s1_valid <= 1'b0;
            r_s1_dz    <= 1'b0;
            r_s1_ovf   <= 1'b0;
        end
    end

    // Tracking stage lines up with the divider's registered q/r.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s2_valid    <= 1'b0;
            r_s2_dz       <= 1'b0;
            r_s2_ovf      <= 1'b0;
            r_s2_dividend <= '0;
        end else begin
            r_s2_valid    <= r_s1_valid;
            r_s2_dz       <= r_s1_dz;
            r_s2_ovf      <= r_s1_ovf;
            r_s2_dividend <= r_data1;
        end
    end

    always_comb begin
        res_valid = r_s2_valid;
        res_dz    = r_s2_valid && r_s2_dz;
        res_ovf   = r_s2_valid && r_s2_ovf;
        res_q     = div_q;
        res_r     = div_r;
        if (r_s2_dz) begin
            res_q = '1;
            res_r = r_s2_dividend;
        end
    end
endmodule

// File: tb/tb_div_operand_queue.sv
// Randomized and directed bench for div_operand_queue with a divider model
// and a queue-based reference of the operand/result stream.
module tb_div_operand_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH+1);
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_dividend = '0;
    logic [WIDTH-1:0]  in_divisor = '0;
    logic              issue_en = 1'b0;
    logic [WIDTH-1:0]  data1;
    logic [WIDTH-1:0]  data2;
    logic [WIDTH-1:0]  div_q;
    logic [WIDTH-1:0]  div_r;
    logic              res_valid;
    logic [WIDTH-1:0]  res_q;
    logic [WIDTH-1:0]  res_r;
    logic              res_dz;
    logic              res_ovf;
    logic [LW-1:0]     level;

    div_operand_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .issue_en(issue_en), .data1(data1), .data2(data2),
        .div_q(div_q), .div_r(div_r),
        .res_valid(res_valid), .res_q(res_q), .res_r(res_r),
        .res_dz(res_dz), .res_ovf(res_ovf), .level(level)
    );

    always #5 clock = ~clock;

    // Downstream one-cycle integer divider
    always @(posedge clock) begin
        if (!reset_n) begin
            div_q <= '0;
            div_r <= '0;
        end else if (data2 == '0) begin
            div_q <= '0;
            div_r <= '0;
        end else begin
            div_q <= $signed(data1) / $signed(data2);
            div_r <= $signed(data1) % $signed(data2);
        end
    end

    typedef struct {
        int unsigned due;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
    } res_t;

    logic [63:0] fifo_m[$];
    res_t        due_q[$];
    res_t        exp_r;
    logic        exp_valid = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic res_t ref_res(input logic [31:0] a, input logic [31:0] b);
        res_t t;
        t.due = 0;
        t.dz  = (b == 32'h0);
        t.ovf = (a == MIN_INT) && (b == 32'hFFFF_FFFF);
        if (t.dz) begin
            t.q = 32'hFFFF_FFFF;
            t.r = a;
        end else if (t.ovf) begin
            t.q = MIN_INT;
            t.r = 32'h0;
        end else begin
            t.q = $signed(a) / $signed(b);
            t.r = $signed(a) % $signed(b);
        end
        return t;
    endfunction

    task automatic tick(input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic ie);
        bit push;
        bit pop;
        logic [63:0] p;
        res_t t;
        in_valid    = v;
        in_dividend = a;
        in_divisor  = b;
        issue_en    = ie;
        push = v && (fifo_m.size() != DEPTH);
        pop  = ie && (fifo_m.size() != 0);
        @(posedge clock);
        cyc++;
        if (pop) begin
            p = fifo_m.pop_front();
            t = ref_res(p[63:32], p[31:0]);
            t.due = cyc + 1;
            due_q.push_back(t);
        end
        if (push)
            fifo_m.push_back({a, b});
        #1;
        exp_valid = 1'b0;
        if (due_q.size() != 0 && due_q[0].due == cyc) begin
            exp_valid = 1'b1;
            exp_r = due_q.pop_front();
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        issue_en = 1'b0;
        @(posedge clock);
        cyc++;
        fifo_m.delete();
        due_q.delete();
        #1;
        exp_valid = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (level !== '0 || in_ready !== 1'b1)
            $display("FAIL reset_fifo level=%0d in_ready=%b req 0/1", level, in_ready);
        else n_pass++;
        n_checks++;
        if (data1 !== 32'h0 || data2 !== 32'h1)
            $display("FAIL reset_data data1=%h data2=%h req 0/1", data1, data2);
        else n_pass++;
        n_checks++;
        if (res_valid !== 1'b0 || res_dz !== 1'b0 || res_ovf !== 1'b0)
            $display("FAIL reset_res v=%b dz=%b ovf=%b req 000", res_valid, res_dz, res_ovf);
        else n_pass++;
    endtask

    task automatic test_single();
        tick(1'b1, 32'd100, 32'd7, 1'b1);
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        n_checks++;
        if (res_valid !== 1'b0 || data1 !== 32'd100 || data2 !== 32'd7)
            $display("FAIL single_issue v=%b d1=%0d d2=%0d req 0/100/7", res_valid, data1, data2);
        else n_pass++;
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        n_checks++;
        if (res_valid !== 1'b1 || res_q !== 32'd14 || res_r !== 32'd2 ||
            res_dz !== 1'b0 || res_ovf !== 1'b0)
            $display("FAIL single_result v=%b q=%0d r=%0d req 1/14/2", res_valid, res_q, res_r);
        else n_pass++;
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        n_checks++;
        if (res_valid !== 1'b0)
            $display("FAIL single_pulse v=%b req 0", res_valid);
        else n_pass++;
    endtask

    task automatic test_signed();
        logic [31:0] ea [3];
        logic [31:0] eb [3];
        logic [31:0] pa [3];
        logic [31:0] pb [3];
        int got;
        int first;
        pa[0] = -32'sd100; pb[0] = 32'd7;
        pa[1] = 32'd100;   pb[1] = -32'sd7;
        pa[2] = -32'sd7;   pb[2] = 32'd100;
        ea[0] = -32'sd14;  eb[0] = -32'sd2;
        ea[1] = -32'sd14;  eb[1] = 32'd2;
        ea[2] = 32'd0;     eb[2] = -32'sd7;
        got = 0;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) tick(1'b1, pa[i], pb[i], 1'b1);
            else tick(1'b0, 32'd0, 32'd0, 1'b1);
            if (res_valid === 1'b1) begin
                if (got == 0) first = i;
                n_checks++;
                if (got > 2 || i != first + got || res_q !== ea[got] || res_r !== eb[got])
                    $display("FAIL signed_%0d q=%0d r=%0d at %0d req q=%0d r=%0d",
                             got, $signed(res_q), $signed(res_r), i,
                             $signed(ea[got % 3]), $signed(eb[got % 3]));
                else n_pass++;
                got++;
            end
        end
        n_checks++;
        if (got != 3)
            $display("FAIL signed_count got=%0d req 3", got);
        else n_pass++;
    endtask

    task automatic test_div_zero();
        tick(1'b1, 32'd1234, 32'd0, 1'b1);
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        n_checks++;
        if (data2 !== 32'd1 || data1 !== 32'd1234)
            $display("FAIL dz_issue d1=%0d d2=%0d req 1234/1", data1, data2);
        else n_pass++;
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        n_checks++;
        if (res_valid !== 1'b1 || res_q !== 32'hFFFF_FFFF || res_r !== 32'd1234 ||
            res_dz !== 1'b1 || res_ovf !== 1'b0)
            $display("FAIL dz_result v=%b q=%h r=%0d dz=%b ovf=%b req 1/ffffffff/1234/1/0",
                     res_valid, res_q, res_r, res_dz, res_ovf);
        else n_pass++;
        tick(1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    task automatic test_overflow();
        tick(1'b1, MIN_INT, 32'hFFFF_FFFF, 1'b1);
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        n_checks++;
        if (data2 !== 32'd1)
            $display("FAIL ovf_issue d2=%h req 1", data2);
        else n_pass++;
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        n_checks++;
        if (res_valid !== 1'b1 || res_q !== MIN_INT || res_r !== 32'd0 ||
            res_dz !== 1'b0 || res_ovf !== 1'b1)
            $display("FAIL ovf_result v=%b q=%h r=%h dz=%b ovf=%b req 1/80000000/0/0/1",
                     res_valid, res_q, res_r, res_dz, res_ovf);
        else n_pass++;
        tick(1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    task automatic test_full();
        int got;
        int first;
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 32'(1000 * (k + 1) + 5), 32'(k + 3), 1'b0);
            n_checks++;
            if (level !== LW'(fifo_m.size()) || in_ready !== (fifo_m.size() != DEPTH))
                $display("FAIL full_fill_%0d level=%0d rdy=%b req %0d", k, level, in_ready,
                         fifo_m.size());
            else n_pass++;
        end
        n_checks++;
        if (level !== LW'(4) || in_ready !== 1'b0)
            $display("FAIL full_state level=%0d rdy=%b req 4/0", level, in_ready);
        else n_pass++;
        tick(1'b0, 32'd0, 32'd0, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1 || level !== LW'(3))
            $display("FAIL full_release rdy=%b level=%0d req 1/3", in_ready, level);
        else n_pass++;
        got = 0;
        first = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 32'd0, 32'd0, 1'b1);
            if (res_valid === 1'b1) begin
                if (got == 0) first = i;
                n_checks++;
                if (!exp_valid || i != first + got || res_q !== exp_r.q || res_r !== exp_r.r ||
                    res_q !== 32'(($signed(32'(1000 * (got + 1) + 5))) / (got + 3)))
                    $display("FAIL full_drain_%0d q=%0d r=%0d req q=%0d r=%0d", got,
                             res_q, res_r, exp_r.q, exp_r.r);
                else n_pass++;
                got++;
            end
        end
        n_checks++;
        if (got != 4)
            $display("FAIL full_count got=%0d req 4", got);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad;
        tick(1'b1, 32'd50, 32'd5, 1'b1);
        tick(1'b1, 32'd60, 32'd6, 1'b1);
        tick(1'b1, 32'd70, 32'd7, 1'b0);
        do_reset();
        n_checks++;
        if (level !== '0 || data2 !== 32'd1 || res_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_mid level=%0d d2=%0d v=%b rdy=%b req 0/1/0/1",
                     level, data2, res_valid, in_ready);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 32'd0, 32'd0, 1'b1);
            if (res_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL rst_mid_stale pulses=%0d req 0", bad);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        v;
        logic        ie;
        int          errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            v  = (i < 390) && ($urandom_range(0, 3) != 0);
            ie = (i >= 390) || ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: a = MIN_INT;
                1: a = 32'($urandom_range(0, 200)) - 32'd100;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(0, 20)) - 32'd10;
                default: b = $urandom;
            endcase
            tick(v, a, b, ie);
            n_checks++;
            if (level !== LW'(fifo_m.size()) || in_ready !== (fifo_m.size() != DEPTH) ||
                res_valid !== exp_valid) begin
                if (errs < 10)
                    $display("FAIL rand_ctl cyc=%0d lvl=%0d v=%b req lvl=%0d v=%b", i,
                             level, res_valid, fifo_m.size(), exp_valid);
                errs++;
            end else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if (res_q !== exp_r.q || res_r !== exp_r.r ||
                    res_dz !== exp_r.dz || res_ovf !== exp_r.ovf) begin
                    if (errs < 10)
                        $display("FAIL rand_res cyc=%0d q=%h r=%h dz=%b ovf=%b req %h %h %b %b",
                                 i, res_q, res_r, res_dz, res_ovf,
                                 exp_r.q, exp_r.r, exp_r.dz, exp_r.ovf);
                    errs++;
                end else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_div_zero();
        test_overflow();
        test_full();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
